// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Brief    : Two-port data-memory arbiter with alternating priority and
//            read-modify-write handling for partial-byte stores.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [1:0]                req_valid,
  output logic [1:0]                req_ready,
  input  logic [1:0]                req_we,
  input  logic [DATA_WIDTH-1:0]     req_addr0,
  input  logic [DATA_WIDTH-1:0]     req_addr1,
  input  logic [DATA_WIDTH-1:0]     req_wdata0,
  input  logic [DATA_WIDTH-1:0]     req_wdata1,
  input  logic [DATA_WIDTH/8-1:0]   req_be0,
  input  logic [DATA_WIDTH/8-1:0]   req_be1,
  output logic [1:0]                resp_valid,
  output logic [DATA_WIDTH-1:0]     resp_rdata,
  output logic                      mem_we,
  output logic [ADDRESS_WIDTH-1:0]  mem_a,
  output logic [DATA_WIDTH-1:0]     mem_wd,
  input  logic [DATA_WIDTH-1:0]     mem_rd
);

  localparam int c_BE_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    RMW_WR = 1'b1
  } state_t;

  state_t                     r_state;
  state_t                     w_state_nxt;
  logic                       r_last;
  logic                       r_rmw_port;
  logic [ADDRESS_WIDTH-1:0]   r_rmw_idx;
  logic [DATA_WIDTH-1:0]      r_rmw_data;
  logic [ADDRESS_WIDTH-1:0]   r_mem_a;
  logic [DATA_WIDTH-1:0]      r_mem_wd;
  logic [1:0]                 r_resp_valid;
  logic [DATA_WIDTH-1:0]      r_resp_rdata;

  logic                       w_grant;
  logic                       w_port;
  logic [DATA_WIDTH-1:0]      w_addr;
  logic [DATA_WIDTH-1:0]      w_wdata;
  logic [c_BE_WIDTH-1:0]      w_be;
  logic                       w_we;
  logic [ADDRESS_WIDTH-1:0]   w_idx;
  logic                       w_partial;
  logic [DATA_WIDTH-1:0]      w_merged;
  logic [1:0]                 w_resp_valid_nxt;
  logic [DATA_WIDTH-1:0]      w_resp_rdata_nxt;
  logic                       w_unused;

  // Contention goes to the port that did not win last time.
  assign w_grant   = (r_state == IDLE) && (|req_valid) && !rst;
  assign w_port    = (&req_valid) ? ~r_last : req_valid[1];
  assign w_addr    = w_port ? req_addr1  : req_addr0;
  assign w_wdata   = w_port ? req_wdata1 : req_wdata0;
  assign w_be      = w_port ? req_be1    : req_be0;
  assign w_we      = req_we[w_port];
  assign w_idx     = w_addr[ADDRESS_WIDTH+1:2];
  assign w_partial = w_we && !(&w_be) && (|w_be);
  assign w_unused  = &{1'b0, w_addr[DATA_WIDTH-1:ADDRESS_WIDTH+2], w_addr[1:0]};

  generate
    for (genvar i = 0; i < c_BE_WIDTH; i++) begin : g_merge
      assign w_merged[8*i +: 8] = w_be[i] ? w_wdata[8*i +: 8] : mem_rd[8*i +: 8];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt      = r_state;
    req_ready        = 2'b00;
    mem_we           = 1'b0;
    mem_a            = r_mem_a;
    mem_wd           = r_mem_wd;
    w_resp_valid_nxt = 2'b00;
    w_resp_rdata_nxt = '0;
    case (r_state)
      IDLE: begin
        if (w_grant) begin
          req_ready = {w_port, ~w_port};
          mem_a     = w_idx;
          if (!w_we) begin
            w_resp_valid_nxt = {w_port, ~w_port};
            w_resp_rdata_nxt = mem_rd;
          end else if (w_partial) begin
            w_state_nxt = RMW_WR;
          end else begin
            // Full store writes now; a null store only acknowledges.
            mem_we           = &w_be;
            mem_wd           = (&w_be) ? w_wdata : r_mem_wd;
            w_resp_valid_nxt = {w_port, ~w_port};
          end
        end
      end
      RMW_WR: begin
        mem_we           = 1'b1;
        mem_a            = r_rmw_idx;
        mem_wd           = r_rmw_data;
        w_resp_valid_nxt = {r_rmw_port, ~r_rmw_port};
        w_state_nxt      = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last       <= 1'b1;
      r_rmw_port   <= 1'b0;
      r_rmw_idx    <= '0;
      r_rmw_data   <= '0;
      r_mem_a      <= '0;
      r_mem_wd     <= '0;
      r_resp_valid <= 2'b00;
      r_resp_rdata <= '0;
    end else begin
      r_mem_a      <= mem_a;
      r_mem_wd     <= mem_wd;
      r_resp_valid <= w_resp_valid_nxt;
      r_resp_rdata <= w_resp_rdata_nxt;
      if (w_grant) r_last <= w_port;
      if (w_grant && w_partial) begin
        r_rmw_port <= w_port;
        r_rmw_idx  <= w_idx;
        r_rmw_data <= w_merged;
      end
    end
  end

  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_arbiter
// Brief    : Directed and randomized bench for dmem_arbiter against a
//            transaction-level model of arbitration and memory contents.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

  logic        clk;
  logic        rst;
  logic [1:0]  req_valid, req_ready, req_we, resp_valid;
  logic [31:0] req_addr0, req_addr1, req_wdata0, req_wdata1, resp_rdata;
  logic [3:0]  req_be0, req_be1;
  logic        mem_we;
  logic [7:0]  mem_a;
  logic [31:0] mem_wd, mem_rd;

  logic [31:0] mem     [256];
  logic [31:0] ref_mem [256];

  int          total = 0;
  int          bad   = 0;

  // model state: pending partial write, last winner, response due next check
  logic        pend;
  logic        pend_port;
  logic [7:0]  pend_idx;
  logic [31:0] pend_data;
  logic        last;
  logic [7:0]  hold_a;
  logic        hold_ok;
  logic [1:0]  exp_rv;
  logic [31:0] exp_rd;
  logic [1:0]  obs_ready;
  logic        obs_we;

  dmem_arbiter #(.ADDRESS_WIDTH(8), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr0(req_addr0), .req_addr1(req_addr1),
    .req_wdata0(req_wdata0), .req_wdata1(req_wdata1),
    .req_be0(req_be0), .req_be1(req_be1),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rd = mem[mem_a];
  always @(posedge clk) if (mem_we) mem[mem_a] <= mem_wd;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [1:0] v, input logic [1:0] we,
                       input logic [31:0] a0, input logic [31:0] a1,
                       input logic [31:0] d0, input logic [31:0] d1,
                       input logic [3:0] b0, input logic [3:0] b1);
    req_valid = v;  req_we = we;
    req_addr0 = a0; req_addr1 = a1;
    req_wdata0 = d0; req_wdata1 = d1;
    req_be0 = b0;   req_be1 = b1;
  endtask

  // Evaluated mid-cycle: predicts this cycle's handshake/memory activity
  // from the request rules and the shadow memory, and checks the response
  // that the previous cycle should have produced.
  task automatic check_cycle();
    logic [1:0]  e_ready, n_rv;
    logic        e_we, chk_a, p, we;
    logic [7:0]  e_a, idx;
    logic [31:0] e_wd, n_rd, a, wd;
    logic [3:0]  be;
    e_ready = 2'b00; e_we = 1'b0; e_a = hold_a; e_wd = '0; chk_a = hold_ok;
    n_rv = 2'b00; n_rd = '0;
    obs_ready = req_ready; obs_we = mem_we;
    if (rst) begin
      pend = 1'b0; last = 1'b1; hold_ok = 1'b0; chk_a = 1'b0;
      exp_rv = 2'b00; exp_rd = '0;
      chk("rst_rdata", resp_rdata, 32'h0);
    end else if (pend) begin
      e_we = 1'b1; e_a = pend_idx; e_wd = pend_data; chk_a = 1'b1;
      ref_mem[pend_idx] = pend_data;
      n_rv = pend_port ? 2'b10 : 2'b01;
      pend = 1'b0;
    end else if (req_valid != 2'b00) begin
      p    = (req_valid == 2'b11) ? !last : req_valid[1];
      last = p;
      a    = p ? req_addr1 : req_addr0;
      wd   = p ? req_wdata1 : req_wdata0;
      be   = p ? req_be1 : req_be0;
      we   = req_we[p];
      idx  = 8'((a >> 2) % 256);
      e_ready = p ? 2'b10 : 2'b01; e_a = idx; chk_a = 1'b1;
      if (!we) begin
        n_rv = e_ready; n_rd = ref_mem[idx];
      end else if (be == 4'hF) begin
        e_we = 1'b1; e_wd = wd; ref_mem[idx] = wd; n_rv = e_ready;
      end else if (be == 4'h0) begin
        n_rv = e_ready;
      end else begin
        pend = 1'b1; pend_port = p; pend_idx = idx;
        for (int b = 0; b < 4; b++)
          pend_data[8*b +: 8] = be[b] ? wd[8*b +: 8] : ref_mem[idx][8*b +: 8];
      end
    end
    chk("req_ready", {30'd0, req_ready}, {30'd0, e_ready});
    chk("mem_we", {31'd0, mem_we}, {31'd0, e_we});
    if (chk_a) chk("mem_a", {24'd0, mem_a}, {24'd0, e_a});
    if (e_we) chk("mem_wd", mem_wd, e_wd);
    chk("resp_valid", {30'd0, resp_valid}, {30'd0, exp_rv});
    if (exp_rv != 2'b00) chk("resp_rdata", resp_rdata, exp_rd);
    if (chk_a && !rst) begin hold_a = e_a; hold_ok = 1'b1; end
    exp_rv = n_rv; exp_rd = n_rd;
  endtask

  task automatic tick();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int nmis;
    logic [31:0] w6;
    for (int i = 0; i < 256; i++) begin
      mem[i] = $urandom; ref_mem[i] = mem[i];
    end
    mem[3] = 32'hA5A5A5A5; mem[4] = 32'h11223344; mem[5] = 32'h55555555;
    ref_mem[3] = mem[3]; ref_mem[4] = mem[4]; ref_mem[5] = mem[5];
    w6 = mem[6];
    pend = 1'b0; last = 1'b1; hold_a = '0; hold_ok = 1'b0;
    exp_rv = 2'b00; exp_rd = '0;

    // reset with both ports requesting: nothing may be granted
    rst = 1'b1;
    drive(2'b11, 2'b00, 32'h0C, 32'h0C, 0, 0, 4'h0, 4'h0);
    tick(); tick();
    chk("rst_ready", {30'd0, obs_ready}, 32'h0);
    chk("rst_resp", {30'd0, resp_valid}, 32'h0);
    rst = 1'b0;

    // both ports load word 3 every cycle: alternation starting with port 0
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("alt_grant", {30'd0, obs_ready}, (i % 2 == 1) ? 32'h2 : 32'h1);
    end
    chk("alt_rdata", resp_rdata, 32'hA5A5A5A5);

    // port 1 partial store into word 4, port 0 held off during the write
    drive(2'b10, 2'b10, 32'h0, 32'h10, 0, 32'h0000AB00, 4'h0, 4'b0010);
    tick();
    chk("rmw_grant_we", {31'd0, obs_we}, 32'h0);
    drive(2'b01, 2'b00, 32'h10, 32'h0, 0, 0, 4'h0, 4'h0);
    tick();
    chk("rmw_holdoff", {30'd0, obs_ready}, 32'h0);
    chk("rmw_word4", mem[4], 32'h1122AB44);
    tick();
    chk("rmw_load_back", resp_rdata, 32'h1122AB44);

    // full store then load back through port 0
    drive(2'b01, 2'b01, 32'h10, 32'h0, 32'hDEADBEEF, 0, 4'hF, 4'h0);
    tick();
    chk("full_we", {31'd0, obs_we}, 32'h1);
    drive(2'b01, 2'b00, 32'hFFFF_0013, 32'h0, 0, 0, 4'h0, 4'h0);
    tick();
    chk("full_load_back", resp_rdata, 32'hDEADBEEF);

    // null store leaves word 5 alone
    drive(2'b01, 2'b01, 32'h14, 32'h0, 32'h12345678, 0, 4'h0, 4'h0);
    tick();
    chk("null_we", {31'd0, obs_we}, 32'h0);
    drive(2'b00, 2'b00, 0, 0, 0, 0, 4'h0, 4'h0);
    tick();
    chk("null_word5", mem[5], 32'h55555555);

    // reset pulsed during the write phase of a partial store to word 6
    drive(2'b01, 2'b01, 32'h18, 32'h0, 32'h000000FF, 0, 4'b0001, 4'h0);
    tick();
    drive(2'b11, 2'b00, 32'h0C, 32'h0C, 0, 0, 4'h0, 4'h0);
    #1 rst = 1'b1;
    #1;
    chk("abort_we", {31'd0, mem_we}, 32'h0);
    chk("abort_resp", {30'd0, resp_valid}, 32'h0);
    tick();
    #1 rst = 1'b0;
    tick();
    chk("post_rst_grant", {30'd0, obs_ready}, 32'h1);
    drive(2'b00, 2'b00, 0, 0, 0, 0, 4'h0, 4'h0);
    tick();
    chk("abort_word6", mem[6], w6);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      logic [3:0] b0, b1;
      b0 = ($urandom_range(0, 2) == 0) ? 4'hF : (($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom));
      b1 = ($urandom_range(0, 2) == 0) ? 4'hF : (($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom));
      drive(2'($urandom), 2'($urandom),
            {$urandom_range(0, 255), 2'($urandom), 4'($urandom), 2'($urandom)} ,
            $urandom, $urandom, $urandom, b0, b1);
      tick();
    end
    drive(2'b00, 2'b00, 0, 0, 0, 0, 4'h0, 4'h0);
    tick(); tick(); tick();

    nmis = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) nmis++;
    chk("final_mem_words", nmis, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
